// File: rtl/pipeline_sequencer.sv
// rtl/pipeline_sequencer.sv - run-control and hazard-stall sequencer for a 5-stage MIPS pipeline
module pipeline_sequencer #(
  parameter int DRAIN_CYCLES = 3,
  parameter int REG_ADDR_W   = 5,
  parameter int CNT_W        = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic                  i_step,
  input  logic [REG_ADDR_W-1:0] i_id_rs,
  input  logic [REG_ADDR_W-1:0] i_id_rt,
  input  logic                  i_id_uses_rs,
  input  logic                  i_id_uses_rt,
  input  logic                  i_id_is_branch,
  input  logic                  i_id_halt,
  input  logic                  i_branch_taken,
  input  logic                  i_ex_reg_write,
  input  logic                  i_ex_mem_read,
  input  logic [REG_ADDR_W-1:0] i_ex_dst,
  input  logic                  i_mem_mem_read,
  input  logic [REG_ADDR_W-1:0] i_mem_dst,
  output logic                  o_pipe_en,
  output logic                  o_pc_write,
  output logic                  o_ifid_write,
  output logic                  o_ifid_flush,
  output logic                  o_idex_bubble,
  output logic [2:0]            o_state,
  output logic                  o_done,
  output logic [CNT_W-1:0]      o_issue_cnt,
  output logic [CNT_W-1:0]      o_stall_cnt
);

  localparam int DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRN_W-1:0] DRN_LOAD = DRN_W'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_STEP  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [DRN_W-1:0]   drain_q, drain_d;
  logic [CNT_W-1:0]   issue_cnt_q, stall_cnt_q;

  logic ex_match, mem_match, hazard, active, stall, issue;

  // r0 is hard-wired zero, so a write to it can never feed a consumer
  assign ex_match  = (i_ex_dst != '0) &&
                     ((i_id_uses_rs && (i_id_rs == i_ex_dst)) ||
                      (i_id_uses_rt && (i_id_rt == i_ex_dst)));
  assign mem_match = (i_mem_dst != '0) &&
                     ((i_id_uses_rs && (i_id_rs == i_mem_dst)) ||
                      (i_id_uses_rt && (i_id_rt == i_mem_dst)));

  // ID-resolved branches need operands one stage earlier than ALU ops
  assign hazard = (i_ex_mem_read && ex_match) ||
                  (i_id_is_branch && i_ex_reg_write && ex_match) ||
                  (i_id_is_branch && i_mem_mem_read && mem_match);

  assign active = (state_q == S_RUN) || (state_q == S_STEP);
  assign stall  = active && hazard;
  assign issue  = active && !hazard;

  always_comb begin
    state_d       = state_q;
    drain_d       = drain_q;
    o_pipe_en     = 1'b0;
    o_pc_write    = 1'b0;
    o_ifid_write  = 1'b0;
    o_ifid_flush  = 1'b0;
    o_idex_bubble = 1'b0;
    o_done        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start)     state_d = S_RUN;
        else if (i_step) state_d = S_STEP;
      end
      S_RUN, S_STEP: begin
        o_pipe_en     = 1'b1;
        o_pc_write    = !stall;
        o_ifid_write  = !stall;
        o_idex_bubble = stall;
        o_ifid_flush  = issue && (i_branch_taken || i_id_halt);
        if (issue && i_id_halt) begin
          state_d = S_DRAIN;
          drain_d = DRN_LOAD;
        end else if (issue && (state_q == S_STEP)) begin
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        // fetch is frozen and IF/ID squashed so only older work retires
        o_pipe_en    = 1'b1;
        o_ifid_write = 1'b1;
        o_ifid_flush = 1'b1;
        if (drain_q == '0) state_d = S_DONE;
        else               drain_d = drain_q - 1'b1;
      end
      S_DONE: begin
        o_done = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      drain_q     <= '0;
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      if (issue) issue_cnt_q <= issue_cnt_q + CNT_W'(1);
      if (stall) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign o_state     = state_q;
  assign o_issue_cnt = issue_cnt_q;
  assign o_stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// tb/tb_pipeline_sequencer.sv - self-checking bench for pipeline_sequencer
module tb_pipeline_sequencer;

  localparam int DRAIN = 3;
  localparam int RW    = 5;
  localparam int CW    = 32;
  localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_DRAIN = 3, M_DONE = 4;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b1;
  logic          i_start, i_step;
  logic [RW-1:0] i_id_rs, i_id_rt, i_ex_dst, i_mem_dst;
  logic          i_id_uses_rs, i_id_uses_rt, i_id_is_branch, i_id_halt, i_branch_taken;
  logic          i_ex_reg_write, i_ex_mem_read, i_mem_mem_read;
  logic          o_pipe_en, o_pc_write, o_ifid_write, o_ifid_flush, o_idex_bubble, o_done;
  logic [2:0]    o_state;
  logic [CW-1:0] o_issue_cnt, o_stall_cnt;

  int            n_checks = 0;
  int            n_fail   = 0;
  int            m_state, m_drain;
  logic [CW-1:0] m_issue, m_stall;
  logic [5:0]    got, exp;

  pipeline_sequencer #(.DRAIN_CYCLES(DRAIN), .REG_ADDR_W(RW), .CNT_W(CW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_step(i_step),
    .i_id_rs(i_id_rs), .i_id_rt(i_id_rt), .i_id_uses_rs(i_id_uses_rs),
    .i_id_uses_rt(i_id_uses_rt), .i_id_is_branch(i_id_is_branch), .i_id_halt(i_id_halt),
    .i_branch_taken(i_branch_taken), .i_ex_reg_write(i_ex_reg_write),
    .i_ex_mem_read(i_ex_mem_read), .i_ex_dst(i_ex_dst), .i_mem_mem_read(i_mem_mem_read),
    .i_mem_dst(i_mem_dst), .o_pipe_en(o_pipe_en), .o_pc_write(o_pc_write),
    .o_ifid_write(o_ifid_write), .o_ifid_flush(o_ifid_flush), .o_idex_bubble(o_idex_bubble),
    .o_state(o_state), .o_done(o_done), .o_issue_cnt(o_issue_cnt), .o_stall_cnt(o_stall_cnt)
  );

  always #5 i_clk = ~i_clk;

  function automatic bit reads_reg(input logic [RW-1:0] x);
    return (x != 0) && ((i_id_uses_rs && i_id_rs == x) || (i_id_uses_rt && i_id_rt == x));
  endfunction

  function automatic bit m_hazard();
    return (i_ex_mem_read && reads_reg(i_ex_dst)) ||
           (i_id_is_branch && i_ex_reg_write && reads_reg(i_ex_dst)) ||
           (i_id_is_branch && i_mem_mem_read && reads_reg(i_mem_dst));
  endfunction

  // {pipe_en, pc_write, ifid_write, ifid_flush, idex_bubble, done}
  function automatic logic [5:0] m_outs();
    bit s;
    s = m_hazard();
    if (m_state == M_RUN || m_state == M_STEP)
      return {1'b1, !s, !s, !s && (i_branch_taken || i_id_halt), s, 1'b0};
    if (m_state == M_DRAIN) return 6'b101100;
    if (m_state == M_DONE)  return 6'b000001;
    return 6'b000000;
  endfunction

  task automatic clear_inputs();
    i_start = 0; i_step = 0; i_id_rs = 0; i_id_rt = 0; i_id_uses_rs = 0; i_id_uses_rt = 0;
    i_id_is_branch = 0; i_id_halt = 0; i_branch_taken = 0; i_ex_reg_write = 0;
    i_ex_mem_read = 0; i_ex_dst = 0; i_mem_mem_read = 0; i_mem_dst = 0;
  endtask

  task automatic model_reset();
    m_state = M_IDLE; m_drain = 0; m_issue = 0; m_stall = 0;
  endtask

  task automatic tick();
    int ns, nd;
    bit act, s, iss;
    act = (m_state == M_RUN || m_state == M_STEP);
    s   = m_hazard();
    iss = act && !s;
    ns  = m_state;
    nd  = m_drain;
    if (m_state == M_IDLE) begin
      if (i_start) ns = M_RUN;
      else if (i_step) ns = M_STEP;
    end else if (act) begin
      if (iss && i_id_halt) begin ns = M_DRAIN; nd = DRAIN - 1; end
      else if (iss && m_state == M_STEP) ns = M_IDLE;
    end else if (m_state == M_DRAIN) begin
      if (m_drain == 0) ns = M_DONE; else nd = m_drain - 1;
    end
    @(posedge i_clk);
    @(negedge i_clk);
    m_state = ns;
    m_drain = nd;
    if (iss) m_issue = m_issue + 1;
    if (act && s) m_stall = m_stall + 1;
  endtask

  task automatic do_reset();
    clear_inputs();
    i_rst_n = 0;
    model_reset();
    @(negedge i_clk);
    i_rst_n = 1;
  endtask

  task automatic start_run();
    do_reset();
    i_start = 1;
    tick();
    i_start = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    model_reset();
    #2 i_rst_n = 0;
    #1;
    n_checks++;
    if (o_state !== 3'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", o_state); end
    got = {o_pipe_en, o_pc_write, o_ifid_write, o_ifid_flush, o_idex_bubble, o_done};
    n_checks++;
    if (got !== 6'b0) begin n_fail++; $display("FAIL reset_outs got=%b exp=000000", got); end
    n_checks++;
    if (o_issue_cnt !== 0 || o_stall_cnt !== 0) begin
      n_fail++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", o_issue_cnt, o_stall_cnt);
    end
    @(negedge i_clk);
    i_rst_n = 1;
  endtask

  task automatic test_run_halt();
    do_reset();
    i_start = 1;
    #1;
    n_checks++;
    if (o_state !== 3'd0 || o_pipe_en !== 1'b0) begin
      n_fail++; $display("FAIL run_idle got=%0d/%b exp=0/0", o_state, o_pipe_en);
    end
    tick();
    i_start = 0;
    for (int k = 0; k < 5; k++) begin
      i_id_rs = RW'($urandom_range(1, 15)); i_id_uses_rs = 1;
      i_ex_reg_write = 1; i_ex_dst = RW'($urandom_range(16, 31));
      #1;
      got = {o_pipe_en, o_pc_write, o_ifid_write, o_ifid_flush, o_idex_bubble, o_done};
      n_checks++;
      if (o_state !== 3'd1 || got !== 6'b111000) begin
        n_fail++; $display("FAIL run_addi[%0d] got=%0d/%b exp=1/111000", k, o_state, got);
      end
      tick();
    end
    i_id_halt = 1;
    #1;
    n_checks++;
    if (o_ifid_flush !== 1'b1) begin n_fail++; $display("FAIL halt_flush got=%b exp=1", o_ifid_flush); end
    tick();
    clear_inputs();
    for (int k = 0; k < DRAIN; k++) begin
      #1;
      got = {o_pipe_en, o_pc_write, o_ifid_write, o_ifid_flush, o_idex_bubble, o_done};
      n_checks++;
      if (o_state !== 3'd3 || got !== 6'b101100) begin
        n_fail++; $display("FAIL drain[%0d] got=%0d/%b exp=3/101100", k, o_state, got);
      end
      tick();
    end
    #1;
    n_checks++;
    if (o_state !== 3'd4 || o_done !== 1'b1 || o_issue_cnt !== 6 || o_stall_cnt !== 0) begin
      n_fail++; $display("FAIL done got=%0d/%b/%0d/%0d exp=4/1/6/0", o_state, o_done, o_issue_cnt, o_stall_cnt);
    end
    i_start = 1; i_step = 1;
    tick();
    clear_inputs();
    #1;
    n_checks++;
    if (o_state !== 3'd4) begin n_fail++; $display("FAIL done_sticky got=%0d exp=4", o_state); end
  endtask

  task automatic test_load_use();
    start_run();
    i_ex_mem_read = 1; i_ex_dst = 8; i_id_rs = 8; i_id_uses_rs = 1;
    #1;
    n_checks++;
    if (o_pc_write !== 0 || o_ifid_write !== 0 || o_idex_bubble !== 1) begin
      n_fail++; $display("FAIL load_use got=%b%b%b exp=001", o_pc_write, o_ifid_write, o_idex_bubble);
    end
    tick();
    i_ex_mem_read = 0;
    #1;
    n_checks++;
    if (o_stall_cnt !== 1 || o_pc_write !== 1) begin
      n_fail++; $display("FAIL load_use_after got=%0d/%b exp=1/1", o_stall_cnt, o_pc_write);
    end
    tick();
    i_ex_mem_read = 1; i_ex_dst = 0; i_id_rs = 0;
    #1;
    n_checks++;
    if (o_idex_bubble !== 0 || o_pc_write !== 1) begin
      n_fail++; $display("FAIL load_use_r0 got=%b/%b exp=0/1", o_idex_bubble, o_pc_write);
    end
    tick();
    #1;
    n_checks++;
    if (o_stall_cnt !== 1 || o_issue_cnt !== 2) begin
      n_fail++; $display("FAIL load_use_cnt got=%0d/%0d exp=1/2", o_stall_cnt, o_issue_cnt);
    end
  endtask

  task automatic test_branch();
    start_run();
    i_id_is_branch = 1; i_id_rs = 9; i_id_uses_rs = 1; i_ex_reg_write = 1; i_ex_dst = 9;
    #1;
    n_checks++;
    if (o_idex_bubble !== 1 || o_pc_write !== 0) begin
      n_fail++; $display("FAIL br_ex got=%b/%b exp=1/0", o_idex_bubble, o_pc_write);
    end
    tick();
    i_ex_reg_write = 0; i_mem_mem_read = 1; i_mem_dst = 9;
    #1;
    n_checks++;
    if (o_idex_bubble !== 1) begin n_fail++; $display("FAIL br_mem got=%b exp=1", o_idex_bubble); end
    tick();
    i_mem_mem_read = 0; i_branch_taken = 1;
    #1;
    n_checks++;
    if (o_stall_cnt !== 2 || o_ifid_flush !== 1 || o_pc_write !== 1) begin
      n_fail++; $display("FAIL br_issue got=%0d/%b/%b exp=2/1/1", o_stall_cnt, o_ifid_flush, o_pc_write);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_stall_flush();
    start_run();
    i_ex_mem_read = 1; i_ex_dst = 5; i_id_rt = 5; i_id_uses_rt = 1; i_branch_taken = 1;
    #1;
    n_checks++;
    if (o_ifid_flush !== 0 || o_idex_bubble !== 1) begin
      n_fail++; $display("FAIL stall_flush got=%b/%b exp=0/1", o_ifid_flush, o_idex_bubble);
    end
    tick();
    i_ex_mem_read = 0;
    #1;
    n_checks++;
    if (o_ifid_flush !== 1) begin n_fail++; $display("FAIL flush_after got=%b exp=1", o_ifid_flush); end
    tick();
    clear_inputs();
  endtask

  task automatic test_step();
    do_reset();
    i_ex_mem_read = 1; i_ex_dst = 3; i_id_rs = 3; i_id_uses_rs = 1; i_step = 1;
    #1;
    n_checks++;
    if (o_state !== 0 || o_idex_bubble !== 0) begin
      n_fail++; $display("FAIL step_idle got=%0d/%b exp=0/0", o_state, o_idex_bubble);
    end
    tick();
    i_step = 0;
    #1;
    n_checks++;
    if (o_state !== 2 || o_idex_bubble !== 1) begin
      n_fail++; $display("FAIL step_stall got=%0d/%b exp=2/1", o_state, o_idex_bubble);
    end
    tick();
    i_ex_mem_read = 0;
    #1;
    n_checks++;
    if (o_state !== 2 || o_pc_write !== 1) begin
      n_fail++; $display("FAIL step_issue got=%0d/%b exp=2/1", o_state, o_pc_write);
    end
    tick();
    #1;
    n_checks++;
    if (o_state !== 0 || o_issue_cnt !== 1 || o_stall_cnt !== 1) begin
      n_fail++; $display("FAIL step_back got=%0d/%0d/%0d exp=0/1/1", o_state, o_issue_cnt, o_stall_cnt);
    end
    i_start = 1; i_step = 1;
    tick();
    clear_inputs();
    #1;
    n_checks++;
    if (o_state !== 1) begin n_fail++; $display("FAIL start_wins got=%0d exp=1", o_state); end
  endtask

  task automatic test_async_reset();
    start_run();
    i_id_halt = 1;
    tick();
    i_id_halt = 0;
    tick();
    #1;
    n_checks++;
    if (o_state !== 3) begin n_fail++; $display("FAIL pre_reset_drain got=%0d exp=3", o_state); end
    #1 i_rst_n = 0;
    #1;
    n_checks++;
    if (o_state !== 0 || o_issue_cnt !== 0 || o_stall_cnt !== 0 || o_pipe_en !== 0) begin
      n_fail++; $display("FAIL async_reset got=%0d/%0d/%0d/%b exp=0/0/0/0",
                         o_state, o_issue_cnt, o_stall_cnt, o_pipe_en);
    end
    model_reset();
    @(negedge i_clk);
    i_rst_n = 1;
  endtask

  task automatic test_random();
    for (int it = 0; it < 2400; it++) begin
      if (it % 300 == 0) do_reset();
      i_start        = ($urandom_range(0, 15) == 0);
      i_step         = ($urandom_range(0, 15) == 0);
      i_id_rs        = RW'($urandom_range(0, 3));
      i_id_rt        = RW'($urandom_range(0, 3));
      i_ex_dst       = RW'($urandom_range(0, 3));
      i_mem_dst      = RW'($urandom_range(0, 3));
      i_id_uses_rs   = ($urandom_range(0, 1) == 1);
      i_id_uses_rt   = ($urandom_range(0, 1) == 1);
      i_id_is_branch = ($urandom_range(0, 3) == 0);
      i_id_halt      = ($urandom_range(0, 29) == 0);
      i_branch_taken = ($urandom_range(0, 2) == 0);
      i_ex_reg_write = ($urandom_range(0, 1) == 1);
      i_ex_mem_read  = ($urandom_range(0, 2) == 0);
      i_mem_mem_read = ($urandom_range(0, 2) == 0);
      #1;
      exp = m_outs();
      got = {o_pipe_en, o_pc_write, o_ifid_write, o_ifid_flush, o_idex_bubble, o_done};
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL rnd_outs[%0d] got=%b exp=%b", it, got, exp); end
      n_checks++;
      if (o_state !== 3'(m_state)) begin
        n_fail++; $display("FAIL rnd_state[%0d] got=%0d exp=%0d", it, o_state, m_state);
      end
      n_checks++;
      if (o_issue_cnt !== m_issue || o_stall_cnt !== m_stall) begin
        n_fail++; $display("FAIL rnd_cnt[%0d] got=%0d/%0d exp=%0d/%0d",
                           it, o_issue_cnt, o_stall_cnt, m_issue, m_stall);
      end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_run_halt();
    test_load_use();
    test_branch();
    test_stall_flush();
    test_step();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_sequencer.md
Name: pipeline_sequencer

Overview:
- Run-control and hazard-stall controller for the 5-stage MIPS pipeline.
- Sits beside the ID-stage decoder and consumes its decoded control signals from the ID, EX and MEM stages.
- Sequences execution: idle, free run, single-step, and drain on halt.
- Generates PC/IF-ID write enables, bubble insertion, squash and global pipeline enable, and keeps issue and stall statistics.

Parameters:
- DRAIN_CYCLES, 3, cycles spent in DRAIN after halt issues so in-flight instructions reach WB.
- REG_ADDR_W, 5, register-address width.
- CNT_W, 32, width of the issued-instruction and stall counters.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  pulse; IDLE->RUN.
- i_step  in  1  pulse; IDLE->STEP.
- i_id_rs  in  REG_ADDR_W  rs of instruction in ID.
- i_id_rt  in  REG_ADDR_W  rt of instruction in ID.
- i_id_uses_rs  in  1  ID instruction reads rs.
- i_id_uses_rt  in  1  ID instruction reads rt.
- i_id_is_branch  in  1  branch type in ID is BEQ/BNE/JR/JALR (compared in ID).
- i_id_halt  in  1  ID holds the HALT encoding.
- i_branch_taken  in  1  ID branch/jump redirect this cycle.
- i_ex_reg_write  in  1  EX instruction writes a register.
- i_ex_mem_read  in  1  EX instruction is a load.
- i_ex_dst  in  REG_ADDR_W  EX destination register.
- i_mem_mem_read  in  1  MEM instruction is a load.
- i_mem_dst  in  REG_ADDR_W  MEM destination register.
- o_pipe_en  out  1  global enable for all stage registers.
- o_pc_write  out  1  PC update enable.
- o_ifid_write  out  1  IF/ID write enable.
- o_ifid_flush  out  1  squash IF/ID contents.
- o_idex_bubble  out  1  zero control into ID/EX.
- o_state  out  3  IDLE=0, RUN=1, STEP=2, DRAIN=3, DONE=4.
- o_done  out  1  high in DONE.
- o_issue_cnt  out  CNT_W  instructions issued out of ID.
- o_stall_cnt  out  CNT_W  stall cycles.

Behaviour:
- Reset (async, any state or mid-operation): state=IDLE, drain counter=0, o_issue_cnt=0, o_stall_cnt=0. Combinational outputs then follow the IDLE values: o_pipe_en=0, o_pc_write=0, o_ifid_write=0, o_ifid_flush=0, o_idex_bubble=0, o_done=0.
- Match terms: match(x) = (x!=0) && ((i_id_uses_rs && i_id_rs==x) || (i_id_uses_rt && i_id_rt==x)).
- stall = (i_ex_mem_read && match(i_ex_dst)) || (i_id_is_branch && i_ex_reg_write && match(i_ex_dst)) || (i_id_is_branch && i_mem_mem_read && match(i_mem_dst)).
- Stall is evaluated only in RUN/STEP.
- issue = active && !stall, where active = state in {RUN, STEP}.
- Outputs, combinational from state and inputs:
  - IDLE/DONE: o_pipe_en=0, all others 0.
  - RUN/STEP: o_pipe_en=1; o_pc_write=o_ifid_write=!stall; o_idex_bubble=stall.
  - RUN/STEP flush: o_ifid_flush = issue && (i_branch_taken || i_id_halt).
  - DRAIN: o_pipe_en=1, o_pc_write=0, o_ifid_write=1, o_ifid_flush=1, o_idex_bubble=0.
- Priority: stall beats branch flush and halt. A redirect or halt is honoured only in the cycle it issues.
- FSM, registered:
  - IDLE: i_start -> RUN. Else i_step -> STEP. i_start wins when both are asserted.
  - RUN: issue && i_id_halt -> DRAIN, drain counter loaded with DRAIN_CYCLES-1.
  - STEP: issue && i_id_halt -> DRAIN. Else issue -> IDLE. Stalls hold STEP until the instruction issues.
  - DRAIN: counter==0 -> DONE, else decrement.
  - DONE: sticky until reset. i_start/i_step are ignored.
- Counters:
  - o_issue_cnt increments on issue, including the HALT issue.
  - o_stall_cnt increments on every active && stall cycle.
  - Both wrap modulo 2^CNT_W.
- Register 0 never creates a hazard.
- i_start/i_step outside IDLE are ignored.

Test Plan:
- Reset then i_start. Run 5 independent ADDIs, then HALT -> RUN for 6 issue cycles; DRAIN for 3 cycles with o_pc_write=0; DONE with o_issue_cnt=6, o_stall_cnt=0.
- Load-use: EX LW dst=8, ID ADD uses_rs rs=8 -> one cycle of o_pc_write=0, o_ifid_write=0, o_idex_bubble=1; o_stall_cnt=1. Repeat with dst=0 -> no stall.
- Branch hazards: BEQ in ID, EX ADDI dst=9, rs=9 -> 1 stall cycle. Then MEM LW dst=9 -> a further stall cycle; o_stall_cnt=2; branch taken then issues with o_ifid_flush=1.
- Stall plus i_branch_taken same cycle -> o_ifid_flush=0. Next cycle (no stall) -> o_ifid_flush=1.
- i_step in IDLE with load-use stall pending -> STEP for 2 cycles, o_issue_cnt +1, back to IDLE. i_start and i_step together -> RUN.
- Assert i_rst_n=0 mid-DRAIN -> state=0, counters=0, o_pipe_en=0 immediately (asynchronous).
